// File: rtl/valu_group_sequencer_if.sv
// Issue/vALU/VRF bundle of the vector group sequencer; slave = sequencer side, master = environment side.
interface valu_group_sequencer_if #(
    parameter int VLEN = 128,
    parameter int AW   = 5
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [AW-1:0]   cmd_vd;
    logic [AW-1:0]   cmd_vs1;
    logic [AW-1:0]   cmd_vs2;
    logic [VLEN-1:0] cmd_scalar;
    logic [7:0]      cmd_sew;
    logic [3:0]      cmd_lmul;

    logic            rf_rd_en;
    logic [AW-1:0]   rf_rd_addr1;
    logic [AW-1:0]   rf_rd_addr2;
    logic [VLEN-1:0] rf_rd_data1;
    logic [VLEN-1:0] rf_rd_data2;

    logic [VLEN-1:0] alu_in1;
    logic [VLEN-1:0] alu_in2;
    logic [VLEN-1:0] alu_scalar;
    logic [2:0]      alu_op;
    logic [7:0]      alu_sew;
    logic [VLEN-1:0] alu_result;

    logic            rf_wr_en;
    logic [AW-1:0]   rf_wr_addr;
    logic [VLEN-1:0] rf_wr_data;

    logic            busy;
    logic            done;
    logic            err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_vd, cmd_vs1, cmd_vs2, cmd_scalar, cmd_sew, cmd_lmul,
        output cmd_ready,
        output rf_rd_en, rf_rd_addr1, rf_rd_addr2,
        input  rf_rd_data1, rf_rd_data2,
        output alu_in1, alu_in2, alu_scalar, alu_op, alu_sew,
        input  alu_result,
        output rf_wr_en, rf_wr_addr, rf_wr_data,
        output busy, done, err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_vd, cmd_vs1, cmd_vs2, cmd_scalar, cmd_sew, cmd_lmul,
        input  cmd_ready,
        input  rf_rd_en, rf_rd_addr1, rf_rd_addr2,
        output rf_rd_data1, rf_rd_data2,
        input  alu_in1, alu_in2, alu_scalar, alu_op, alu_sew,
        output alu_result,
        input  rf_wr_en, rf_wr_addr, rf_wr_data,
        input  busy, done, err
    );
endinterface

// File: rtl/valu_group_sequencer.sv
// Runs one vALU command over an LMUL register group: read VRF, drive vALU, write back, element by element.
// Latency: 3 cycles per register (RD/EX/WB) plus one DONE cycle; illegal commands finish in one ERR cycle.
// Backpressure: cmd_ready only in IDLE; a held cmd_valid waits there, nothing is dropped.
module valu_group_sequencer #(
    parameter int VLEN = 128,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    valu_group_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_EX,
        ST_WB,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef struct packed {
        logic [2:0]      op;
        logic [AW-1:0]   vd;
        logic [AW-1:0]   vs1;
        logic [AW-1:0]   vs2;
        logic [VLEN-1:0] scalar;
        logic [7:0]      sew;
        logic [3:0]      lmul;
    } cmd_t;

    state_t          state;
    state_t          state_nxt;
    cmd_t            cmd_in;
    cmd_t            cmd_q;
    logic [3:0]      idx;
    logic [AW-1:0]   rd_addr1;
    logic [AW-1:0]   rd_addr2;
    logic [AW-1:0]   wr_addr;
    logic [VLEN-1:0] wr_data;

    logic            ready;
    logic            rd_en;
    logic            wr_en;
    logic            busy;
    logic            done;
    logic            err;
    logic            accept;
    logic            sew_ok;
    logic            lmul_ok;
    logic            cmd_legal;
    logic            last_elem;

    // Group must be LMUL-aligned and end inside the register file.
    function automatic logic grp_ok(input logic [AW-1:0] base, input logic [3:0] lmul);
        logic [AW-1:0] mask;
        mask = AW'(lmul - 4'd1);
        return ((base & mask) == '0) && ((int'(base) + int'(lmul)) <= NREG);
    endfunction

    always_comb begin
        cmd_in = '{op:     bus.cmd_op,
                   vd:     bus.cmd_vd,
                   vs1:    bus.cmd_vs1,
                   vs2:    bus.cmd_vs2,
                   scalar: bus.cmd_scalar,
                   sew:    bus.cmd_sew,
                   lmul:   bus.cmd_lmul};
    end

    always_comb begin
        sew_ok = 1'b0;
        case (bus.cmd_sew)
            8'd8, 8'd16, 8'd32, 8'd64: sew_ok = 1'b1;
            default:                   sew_ok = 1'b0;
        endcase
        lmul_ok = 1'b0;
        case (bus.cmd_lmul)
            4'd1, 4'd2, 4'd4, 4'd8: lmul_ok = 1'b1;
            default:                lmul_ok = 1'b0;
        endcase
        cmd_legal = sew_ok && lmul_ok
                    && grp_ok(bus.cmd_vd,  bus.cmd_lmul)
                    && grp_ok(bus.cmd_vs1, bus.cmd_lmul)
                    && grp_ok(bus.cmd_vs2, bus.cmd_lmul);
    end

    assign last_elem = ({1'b0, idx} + 5'd1) >= {1'b0, cmd_q.lmul};
    assign accept    = ready && bus.cmd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy  = 1'b0;
                ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_nxt = cmd_legal ? ST_RD : ST_ERR;
                end
            end
            ST_RD: begin
                rd_en     = 1'b1;
                state_nxt = ST_EX;
            end
            ST_EX: begin
                state_nxt = ST_WB;
            end
            ST_WB: begin
                wr_en     = 1'b1;
                state_nxt = last_elem ? ST_DONE : ST_RD;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                done      = 1'b1;
                err       = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read addresses are loaded one cycle ahead of RD so the strobe and address line up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q    <= '0;
            idx      <= '0;
            rd_addr1 <= '0;
            rd_addr2 <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            if (accept) begin
                cmd_q <= cmd_in;
                idx   <= '0;
                if (cmd_legal) begin
                    rd_addr1 <= bus.cmd_vs1;
                    rd_addr2 <= bus.cmd_vs2;
                end
            end
            if (state == ST_EX) begin
                wr_data <= bus.alu_result;
                wr_addr <= cmd_q.vd + AW'(idx);
            end
            if (state == ST_WB) begin
                idx <= idx + 4'd1;
                if (!last_elem) begin
                    rd_addr1 <= cmd_q.vs1 + AW'(idx + 4'd1);
                    rd_addr2 <= cmd_q.vs2 + AW'(idx + 4'd1);
                end
            end
        end
    end

    assign bus.cmd_ready   = ready;
    assign bus.rf_rd_en    = rd_en;
    assign bus.rf_rd_addr1 = rd_addr1;
    assign bus.rf_rd_addr2 = rd_addr2;
    assign bus.alu_in1     = bus.rf_rd_data1;
    assign bus.alu_in2     = bus.rf_rd_data2;
    assign bus.alu_scalar  = cmd_q.scalar;
    assign bus.alu_op      = cmd_q.op;
    assign bus.alu_sew     = cmd_q.sew;
    assign bus.rf_wr_en    = wr_en;
    assign bus.rf_wr_addr  = wr_addr;
    assign bus.rf_wr_data  = wr_data;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.err         = err;

endmodule

// File: tb/tb_valu_group_sequencer.sv
// Directed bench: models the VRF and a simple vALU, checks strobe timing and written-back results.
module tb_valu_group_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    valu_group_sequencer_if #(.VLEN(128), .AW(5)) bus ();

    valu_group_sequencer #(.VLEN(128), .NREG(32), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // VRF model: registered read, write and bench preload port.
    logic [127:0] vrf [32];
    logic [127:0] rd1, rd2;
    logic         pl_en;
    logic [4:0]   pl_addr;
    logic [127:0] pl_data;

    always @(posedge clk) begin
        if (bus.rf_rd_en) begin
            rd1 <= vrf[bus.rf_rd_addr1];
            rd2 <= vrf[bus.rf_rd_addr2];
        end
        if (bus.rf_wr_en) vrf[bus.rf_wr_addr] <= bus.rf_wr_data;
        if (pl_en) vrf[pl_addr] <= pl_data;
    end

    assign bus.rf_rd_data1 = rd1;
    assign bus.rf_rd_data2 = rd2;

    // vALU model: op0 element add, op1 in1 + scalar element, op2 xor.
    function automatic logic [127:0] valu(input logic [127:0] a, input logic [127:0] b,
                                          input logic [127:0] s, input logic [2:0] op,
                                          input logic [7:0] sew);
        logic [127:0] r, mask, ae, be;
        int w;
        w = (sew == 8'd8 || sew == 8'd16 || sew == 8'd32 || sew == 8'd64) ? int'(sew) : 8;
        mask = (128'd1 << w) - 128'd1;
        r = '0;
        if (op == 3'd2) return a ^ b;
        for (int e = 0; e < 128 / w; e++) begin
            ae = (a >> (e * w)) & mask;
            be = (op == 3'd1) ? (s & mask) : ((b >> (e * w)) & mask);
            r  = r | (((ae + be) & mask) << (e * w));
        end
        return r;
    endfunction

    assign bus.alu_result = valu(bus.alu_in1, bus.alu_in2, bus.alu_scalar, bus.alu_op, bus.alu_sew);

    task automatic preload(input logic [4:0] addr, input logic [127:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = addr; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic drive_cmd(input logic [2:0] op, input logic [4:0] vd, input logic [4:0] vs1,
                             input logic [4:0] vs2, input logic [127:0] scalar,
                             input logic [7:0] sew, input logic [3:0] lmul);
        bus.cmd_op = op; bus.cmd_vd = vd; bus.cmd_vs1 = vs1; bus.cmd_vs2 = vs2;
        bus.cmd_scalar = scalar; bus.cmd_sew = sew; bus.cmd_lmul = lmul;
    endtask

    // Issues one command and checks every cycle until cmd_ready returns.
    task automatic run_cmd(input string name, input logic [2:0] op, input logic [4:0] vd,
                           input logic [4:0] vs1, input logic [4:0] vs2, input logic [127:0] scalar,
                           input logic [7:0] sew, input logic [3:0] lmul, input bit legal);
        int n;
        logic [4:0] got, exp;
        logic [4:0] ea1, ea2, ew;
        @(negedge clk);
        drive_cmd(op, vd, vs1, vs2, scalar, sew, lmul);
        bus.cmd_valid = 1'b1;
        for (int t = 0; t < 64 && !bus.cmd_ready; t++) @(negedge clk);
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: cmd_ready got %b exp 1", name, bus.cmd_ready);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        n = legal ? 3 * int'(lmul) : 0;
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            if (k == 1) bus.cmd_valid = 1'b0;
            exp = {legal && k <= n && (k % 3 == 1), legal && k <= n && (k % 3 == 0),
                   k == n + 1, !legal && k == 1, k == n + 2};
            got = {bus.rf_rd_en, bus.rf_wr_en, bus.done, bus.err, bus.cmd_ready};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s k=%0d rd/wr/done/err/rdy got %b exp %b", name, k, got, exp);
            end
            if (exp[4]) begin
                ea1 = vs1 + 5'((k - 1) / 3);
                ea2 = vs2 + 5'((k - 1) / 3);
                vectors++;
                if ({bus.rf_rd_addr1, bus.rf_rd_addr2} !== {ea1, ea2}) begin
                    errors++;
                    $display("FAIL %s k=%0d rd_addr got %0d,%0d exp %0d,%0d", name, k,
                             bus.rf_rd_addr1, bus.rf_rd_addr2, ea1, ea2);
                end
            end
            if (exp[3]) begin
                ew = vd + 5'(k / 3 - 1);
                vectors++;
                if (bus.rf_wr_addr !== ew) begin
                    errors++;
                    $display("FAIL %s k=%0d wr_addr got %0d exp %0d", name, k, bus.rf_wr_addr, ew);
                end
            end
            vectors++;
            if ({bus.alu_op, bus.alu_sew, bus.alu_scalar} !== {op, sew, scalar}) begin
                errors++;
                $display("FAIL %s k=%0d alu op/sew got %0d/%0d scalar %h exp %0d/%0d %h", name, k,
                         bus.alu_op, bus.alu_sew, bus.alu_scalar, op, sew, scalar);
            end
        end
    endtask

    task automatic check_reg(input string name, input logic [4:0] r, input logic [127:0] exp);
        vectors++;
        if (vrf[r] !== exp) begin
            errors++;
            $display("FAIL %s vrf[%0d] got %h exp %h", name, r, vrf[r], exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        vectors++;
        if ({bus.rf_rd_en, bus.rf_wr_en, bus.done, bus.err, bus.busy, bus.cmd_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL %s rd/wr/done/err/busy/rdy got %b exp 000001", name,
                     {bus.rf_rd_en, bus.rf_wr_en, bus.done, bus.err, bus.busy, bus.cmd_ready});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        drive_cmd(3'd0, 5'd0, 5'd0, 5'd0, '0, 8'd0, 4'd0);
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        vectors++;
        if ({bus.rf_rd_addr1, bus.rf_rd_addr2, bus.rf_wr_addr, bus.alu_op, bus.alu_sew} !== '0
            || bus.rf_wr_data !== '0 || bus.alu_scalar !== '0) begin
            errors++;
            $display("FAIL reset regs: addr %0d/%0d/%0d op %0d sew %0d exp all 0", bus.rf_rd_addr1,
                     bus.rf_rd_addr2, bus.rf_wr_addr, bus.alu_op, bus.alu_sew);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_release");
    endtask

    task automatic test_single();
        preload(5'd1, 128'h000102030405060708090A0B0C0D0E0F);
        preload(5'd2, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
        run_cmd("single", 3'd0, 5'd3, 5'd1, 5'd2, '0, 8'd8, 4'd1, 1'b1);
        check_reg("single", 5'd3, {16{8'hFF}});
    endtask

    task automatic test_group4();
        for (int r = 8; r < 16; r++) preload(5'(r), {4{32'(r)}});
        run_cmd("group4", 3'd0, 5'd4, 5'd8, 5'd12, '0, 8'd32, 4'd4, 1'b1);
        check_reg("group4", 5'd4, {4{32'd20}});
        check_reg("group4", 5'd5, {4{32'd22}});
        check_reg("group4", 5'd6, {4{32'd24}});
        check_reg("group4", 5'd7, {4{32'd26}});
    endtask

    task automatic test_illegal();
        preload(5'd31, {8{16'hDEAD}});
        run_cmd("ill_sew",   3'd0, 5'd0,  5'd0,  5'd1, '0, 8'd128, 4'd1, 1'b0);
        run_cmd("ill_lmul",  3'd0, 5'd0,  5'd3,  5'd6, '0, 8'd8,   4'd3, 1'b0);
        run_cmd("ill_vd",    3'd0, 5'd5,  5'd0,  5'd2, '0, 8'd16,  4'd2, 1'b0);
        run_cmd("ill_vs1",   3'd0, 5'd0,  5'd30, 5'd4, '0, 8'd32,  4'd4, 1'b0);
        check_reg("ill_noupd", 5'd31, {8{16'hDEAD}});
    endtask

    task automatic test_back_to_back();
        preload(5'd16, {16{8'h0F}});
        preload(5'd17, {16{8'hF3}});
        @(negedge clk);
        drive_cmd(3'd2, 5'd18, 5'd16, 5'd17, 128'h55, 8'd16, 4'd1);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) drive_cmd(3'd0, 5'd19, 5'd16, 5'd17, 128'h33, 8'd8, 4'd1);
            vectors++;
            if ({bus.alu_op, bus.alu_sew, bus.alu_scalar, bus.cmd_ready} !==
                {3'd2, 8'd16, 128'h55, k == 5}) begin
                errors++;
                $display("FAIL b2b_first k=%0d op %0d sew %0d scalar %h rdy %b exp 2 16 55 %b", k,
                         bus.alu_op, bus.alu_sew, bus.alu_scalar, bus.cmd_ready, k == 5);
            end
        end
        @(negedge clk);
        vectors++;
        if ({bus.alu_op, bus.alu_sew, bus.alu_scalar, bus.cmd_ready, bus.busy} !==
            {3'd0, 8'd8, 128'h33, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_second op %0d sew %0d scalar %h rdy %b busy %b exp 0 8 33 0 1",
                     bus.alu_op, bus.alu_sew, bus.alu_scalar, bus.cmd_ready, bus.busy);
        end
        bus.cmd_valid = 1'b0;
        for (int t = 0; t < 10 && !bus.done; t++) @(negedge clk);
        vectors++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done got %b exp 1", bus.done);
        end
        check_reg("b2b_xor", 5'd18, {16{8'hFC}});
        check_reg("b2b_add", 5'd19, {16{8'h02}});
        @(negedge clk);
    endtask

    task automatic test_vx_overlap();
        preload(5'd2, {16{8'h01}});
        preload(5'd3, {16{8'h10}});
        preload(5'd4, {16{8'hAA}});
        preload(5'd5, {16{8'hBB}});
        run_cmd("vx_overlap", 3'd1, 5'd2, 5'd2, 5'd4, 128'h7F, 8'd8, 4'd2, 1'b1);
        check_reg("vx_overlap", 5'd2, {16{8'h80}});
        check_reg("vx_overlap", 5'd3, {16{8'h8F}});
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_cmd(3'd0, 5'd16, 5'd0, 5'd8, 128'h99, 8'd64, 4'd8);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) bus.cmd_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        vectors++;
        if ({bus.rf_rd_addr1, bus.rf_rd_addr2, bus.rf_wr_addr, bus.alu_op, bus.alu_sew} !== '0
            || bus.rf_wr_data !== '0 || bus.alu_scalar !== '0) begin
            errors++;
            $display("FAIL rst_mid regs: addr %0d/%0d/%0d op %0d sew %0d exp all 0", bus.rf_rd_addr1,
                     bus.rf_rd_addr2, bus.rf_wr_addr, bus.alu_op, bus.alu_sew);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_idle_outputs("rst_after");
        end
        preload(5'd0, 128'h1);
        preload(5'd1, {128{1'b1}});
        preload(5'd8, 128'h3);
        preload(5'd9, {16{8'h0F}});
        run_cmd("rst_fresh", 3'd2, 5'd20, 5'd0, 5'd8, '0, 8'd64, 4'd2, 1'b1);
        check_reg("rst_fresh", 5'd20, 128'h2);
        check_reg("rst_fresh", 5'd21, {16{8'hF0}});
    endtask

    initial begin
        test_reset();
        test_single();
        test_group4();
        test_illegal();
        test_back_to_back();
        test_vx_overlap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
